// File: rtl/mem_line_arbiter_pkg.sv
// rtl/mem_line_arbiter_pkg.sv - shared types and helpers for the cacheline arbiter
package mem_line_arbiter_pkg;

  typedef logic [255:0] line_t;
  typedef logic [31:0]  rv32i_word;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_I  = 2'd1,
    BUSY_D  = 2'd2,
    RECOVER = 2'd3
  } arb_state_t;

  localparam logic [3:0] STARVE_MAX = 4'd15;

  // Adaptor works on whole lines, so the byte offset is never forwarded.
  function automatic rv32i_word line_align(input rv32i_word addr);
    return {addr[31:5], 5'b0_0000};
  endfunction

endpackage

// File: rtl/mem_line_arbiter_pick.sv
// rtl/mem_line_arbiter_pick.sv - combinational winner select with starvation bound
module mem_line_arbiter_pick #(
  parameter int STARVE_LIMIT = 2
) (
  input  logic       i_icache_act,
  input  logic       i_dcache_act,
  input  logic [3:0] i_starve_cnt,
  output logic       o_grant_i,
  output logic       o_grant_d
);

  // Dcache wins contested cycles until the icache has lost STARVE_LIMIT in a row.
  always_comb begin
    o_grant_i = 1'b0;
    o_grant_d = 1'b0;
    if (i_icache_act && i_dcache_act) begin
      if (i_starve_cnt >= 4'(STARVE_LIMIT)) begin
        o_grant_i = 1'b1;
      end else begin
        o_grant_d = 1'b1;
      end
    end else begin
      o_grant_i = i_icache_act;
      o_grant_d = i_dcache_act;
    end
  end

endmodule

// File: rtl/mem_line_arbiter.sv
// rtl/mem_line_arbiter.sv - icache/dcache arbiter in front of the cacheline adaptor
module mem_line_arbiter
  import mem_line_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  instr_cache_address,
  input  logic         instr_cache_read,
  input  logic         instr_cache_write,
  input  logic [255:0] instr_cache_to_pmem,
  output logic [255:0] instr_pmem_to_cache,
  output logic         instr_cache_resp,
  input  logic [31:0]  data_cache_address,
  input  logic         data_cache_read,
  input  logic         data_cache_write,
  input  logic [255:0] data_cache_to_pmem,
  output logic [255:0] data_pmem_to_cache,
  output logic         data_cache_resp,
  output logic [31:0]  cache_address,
  output logic         cache_read,
  output logic         cache_write,
  output logic [255:0] cache_to_pmem,
  input  logic [255:0] pmem_to_cache,
  input  logic         cache_resp
);

  arb_state_t r_state;
  arb_state_t w_state_next;
  logic [3:0] r_starve_cnt;
  rv32i_word  r_cache_address;
  logic       r_cache_read;
  logic       r_cache_write;
  line_t      r_cache_to_pmem;

  logic w_icache_act;
  logic w_dcache_act;
  logic w_grant_i;
  logic w_grant_d;
  logic w_idle;
  logic w_busy;

  assign w_icache_act = instr_cache_read | instr_cache_write;
  assign w_dcache_act = data_cache_read | data_cache_write;
  assign w_idle       = (r_state == IDLE);
  assign w_busy       = (r_state == BUSY_I) || (r_state == BUSY_D);

  mem_line_arbiter_pick #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .i_icache_act (w_icache_act),
    .i_dcache_act (w_dcache_act),
    .i_starve_cnt (r_starve_cnt),
    .o_grant_i    (w_grant_i),
    .o_grant_d    (w_grant_d)
  );

  // Next-state: grants only from IDLE, one RECOVER cycle after every response.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_i) begin
          w_state_next = BUSY_I;
        end else if (w_grant_d) begin
          w_state_next = BUSY_D;
        end
      end
      BUSY_I, BUSY_D: begin
        if (cache_resp) begin
          w_state_next = RECOVER;
        end
      end
      RECOVER: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Starvation counter: counts contested dcache wins, cleared by any icache win.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= 4'd0;
    end else if (w_idle && w_grant_i) begin
      r_starve_cnt <= 4'd0;
    end else if (w_idle && w_grant_d && w_icache_act && (r_starve_cnt != STARVE_MAX)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // Downstream command: latched at grant, held through BUSY, op dropped on response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cache_address <= '0;
      r_cache_read    <= 1'b0;
      r_cache_write   <= 1'b0;
      r_cache_to_pmem <= '0;
    end else if (w_idle && w_grant_i) begin
      r_cache_address <= line_align(instr_cache_address);
      r_cache_to_pmem <= instr_cache_to_pmem;
      r_cache_write   <= instr_cache_write;
      r_cache_read    <= instr_cache_read & ~instr_cache_write;
    end else if (w_idle && w_grant_d) begin
      r_cache_address <= line_align(data_cache_address);
      r_cache_to_pmem <= data_cache_to_pmem;
      r_cache_write   <= data_cache_write;
      r_cache_read    <= data_cache_read & ~data_cache_write;
    end else if (w_busy && cache_resp) begin
      r_cache_read    <= 1'b0;
      r_cache_write   <= 1'b0;
    end
  end

  assign cache_address = r_cache_address;
  assign cache_read    = r_cache_read;
  assign cache_write   = r_cache_write;
  assign cache_to_pmem = r_cache_to_pmem;

  // Read data fans out to both caches; only the done strobe is steered.
  assign instr_pmem_to_cache = pmem_to_cache;
  assign data_pmem_to_cache  = pmem_to_cache;
  assign instr_cache_resp    = (r_state == BUSY_I) && cache_resp;
  assign data_cache_resp     = (r_state == BUSY_D) && cache_resp;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// tb/tb_mem_line_arbiter.sv - directed self-checking bench for mem_line_arbiter
module tb_mem_line_arbiter;
  import mem_line_arbiter_pkg::*;

  logic         clk;
  logic         rst;
  logic [31:0]  instr_cache_address;
  logic         instr_cache_read;
  logic         instr_cache_write;
  logic [255:0] instr_cache_to_pmem;
  logic [255:0] instr_pmem_to_cache;
  logic         instr_cache_resp;
  logic [31:0]  data_cache_address;
  logic         data_cache_read;
  logic         data_cache_write;
  logic [255:0] data_cache_to_pmem;
  logic [255:0] data_pmem_to_cache;
  logic         data_cache_resp;
  logic [31:0]  cache_address;
  logic         cache_read;
  logic         cache_write;
  logic [255:0] cache_to_pmem;
  logic [255:0] pmem_to_cache;
  logic         cache_resp;

  int n_total;
  int n_pass;

  mem_line_arbiter #(.STARVE_LIMIT(2)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .instr_cache_address (instr_cache_address),
    .instr_cache_read    (instr_cache_read),
    .instr_cache_write   (instr_cache_write),
    .instr_cache_to_pmem (instr_cache_to_pmem),
    .instr_pmem_to_cache (instr_pmem_to_cache),
    .instr_cache_resp    (instr_cache_resp),
    .data_cache_address  (data_cache_address),
    .data_cache_read     (data_cache_read),
    .data_cache_write    (data_cache_write),
    .data_cache_to_pmem  (data_cache_to_pmem),
    .data_pmem_to_cache  (data_pmem_to_cache),
    .data_cache_resp     (data_cache_resp),
    .cache_address       (cache_address),
    .cache_read          (cache_read),
    .cache_write         (cache_write),
    .cache_to_pmem       (cache_to_pmem),
    .pmem_to_cache       (pmem_to_cache),
    .cache_resp          (cache_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
    return l;
  endfunction

  // One full transaction: grant edge, optional mid-flight request drop, hold
  // cycles, response, RECOVER and return to IDLE.
  task automatic txn(input string tag, input logic [31:0] exp_addr, input logic exp_rd,
                     input logic exp_wr, input logic [255:0] exp_wdata, input logic exp_d,
                     input int lat, input logic drop_mid, input logic drop_end);
    logic [255:0] l;
    tick();
    chk({tag, ".addr"}, cache_address, exp_addr);
    chk({tag, ".rd"}, cache_read, exp_rd);
    chk({tag, ".wr"}, cache_write, exp_wr);
    if (exp_wr) chk({tag, ".wdata"}, cache_to_pmem, exp_wdata);
    if (drop_mid) begin
      data_cache_read    = 1'b0;
      data_cache_write   = 1'b0;
      data_cache_address = 32'h0000_0300;
    end
    for (int c = 0; c < lat; c++) begin
      tick();
      chk({tag, ".hold_addr"}, cache_address, exp_addr);
      chk({tag, ".hold_op"}, {cache_read, cache_write}, {exp_rd, exp_wr});
    end
    l = rand_line();
    pmem_to_cache = l;
    cache_resp    = 1'b1;
    #1;
    chk({tag, ".iresp"}, instr_cache_resp, !exp_d);
    chk({tag, ".dresp"}, data_cache_resp, exp_d);
    chk({tag, ".iline"}, instr_pmem_to_cache, l);
    chk({tag, ".dline"}, data_pmem_to_cache, l);
    tick();
    cache_resp = 1'b0;
    if (drop_end) begin
      if (exp_d) begin
        data_cache_read  = 1'b0;
        data_cache_write = 1'b0;
      end else begin
        instr_cache_read  = 1'b0;
        instr_cache_write = 1'b0;
      end
    end
    chk({tag, ".recover_op"}, {cache_read, cache_write}, 2'b00);
    chk({tag, ".recover_resp"}, {instr_cache_resp, data_cache_resp}, 2'b00);
    tick();
    chk({tag, ".idle_op"}, {cache_read, cache_write}, 2'b00);
  endtask

  initial begin
    logic [255:0] wd;
    logic [3:0]   exp_cnt [6];
    logic         exp_isd [6];
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1;
    instr_cache_address = '0; instr_cache_read = 1'b0; instr_cache_write = 1'b0;
    instr_cache_to_pmem = '0;
    data_cache_address  = '0; data_cache_read  = 1'b0; data_cache_write  = 1'b0;
    data_cache_to_pmem  = '0;
    pmem_to_cache = '0; cache_resp = 1'b0;
    tick();
    tick();
    chk("rst.rd", cache_read, 1'b0);
    chk("rst.wr", cache_write, 1'b0);
    chk("rst.addr", cache_address, 32'h0);
    chk("rst.wdata", cache_to_pmem, 256'h0);
    chk("rst.resp", {instr_cache_resp, data_cache_resp}, 2'b00);
    chk("rst.starve", dut.r_starve_cnt, 4'd0);
    rst = 1'b0;

    // Lone icache read, adaptor answers on the 10th busy cycle.
    instr_cache_address = 32'h0000_0064;
    instr_cache_read    = 1'b1;
    txn("lone_i", 32'h0000_0060, 1'b1, 1'b0, '0, 1'b0, 9, 1'b0, 1'b1);

    // Contested: dcache write wins first, icache follows after the 2-cycle gap.
    wd = rand_line();
    instr_cache_address = 32'h0000_0100;
    instr_cache_read    = 1'b1;
    data_cache_address  = 32'h8000_0020;
    data_cache_write    = 1'b1;
    data_cache_to_pmem  = wd;
    txn("both_d", 32'h8000_0020, 1'b0, 1'b1, wd, 1'b1, 3, 1'b0, 1'b1);
    txn("both_i", 32'h0000_0100, 1'b1, 1'b0, '0, 1'b0, 2, 1'b0, 1'b1);
    chk("both.starve", dut.r_starve_cnt, 4'd0);

    // Continuous contention: D, D, I, D, D, I.
    exp_isd = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_cnt = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0};
    instr_cache_address = 32'h0000_0040;
    instr_cache_read    = 1'b1;
    data_cache_address  = 32'h0000_00A0;
    data_cache_read     = 1'b1;
    for (int g = 0; g < 6; g++) begin
      txn(exp_isd[g] ? "starve_d" : "starve_i", exp_isd[g] ? 32'h0000_00A0 : 32'h0000_0040,
          1'b1, 1'b0, '0, exp_isd[g], 1, 1'b0, 1'b0);
      chk("starve.cnt", dut.r_starve_cnt, exp_cnt[g]);
    end
    instr_cache_read = 1'b0;
    data_cache_read  = 1'b0;

    // Dcache drops its request mid-transaction; downstream stays put.
    data_cache_address = 32'h0000_0200;
    data_cache_read    = 1'b1;
    txn("drop_mid", 32'h0000_0200, 1'b1, 1'b0, '0, 1'b1, 3, 1'b1, 1'b1);

    // Read and write together: only the write goes downstream, offset zeroed.
    wd = rand_line();
    instr_cache_address = 32'h1234_561F;
    instr_cache_read    = 1'b1;
    instr_cache_write   = 1'b1;
    instr_cache_to_pmem = wd;
    txn("rdwr", 32'h1234_5600, 1'b0, 1'b1, wd, 1'b0, 1, 1'b0, 1'b1);

    // Reset while BUSY_I, then a stray adaptor response.
    instr_cache_address = 32'h0000_0400;
    instr_cache_read    = 1'b1;
    tick();
    chk("rstbusy.grant", cache_read, 1'b1);
    rst = 1'b1;
    instr_cache_read = 1'b0;
    tick();
    rst = 1'b0;
    chk("rstbusy.rd", cache_read, 1'b0);
    chk("rstbusy.wr", cache_write, 1'b0);
    chk("rstbusy.state", dut.r_state, IDLE);
    cache_resp = 1'b1;
    #1;
    chk("stray.resp", {instr_cache_resp, data_cache_resp}, 2'b00);
    tick();
    cache_resp = 1'b0;
    chk("stray.rd", cache_read, 1'b0);
    chk("stray.state", dut.r_state, IDLE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_line_arbiter.md
# mem_line_arbiter

Two-requester physical-memory arbiter between the instruction cache and data cache miss/writeback ports and the single cacheline adaptor. Each transaction is latched at grant and held unchanged until the adaptor responds. Data-cache priority is bounded by a starvation limit so instruction fetch always progresses. It owns all sequencing of the shared 256-bit line path.

## Interface
Parameters:
- STARVE_LIMIT, 2, consecutive contested grants the icache may lose before it is forced to win (1..15)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- instr_cache_address  in  32  icache line address (bits [4:0] ignored, forwarded as zero)
- instr_cache_read  in  1  icache line read request
- instr_cache_write  in  1  icache line write request (tied 0 in practice, fully supported)
- instr_cache_to_pmem  in  256  icache writeback line
- instr_pmem_to_cache  out  256  line to icache
- instr_cache_resp  out  1  icache transaction done
- data_cache_address, data_cache_read, data_cache_write, data_cache_to_pmem, data_pmem_to_cache, data_cache_resp: same as icache set, for dcache
- cache_address  out  32  to adaptor, registered
- cache_read  out  1  to adaptor, registered
- cache_write  out  1  to adaptor, registered
- cache_to_pmem  out  256  to adaptor, registered
- pmem_to_cache  in  256  line from adaptor
- cache_resp  in  1  adaptor done, one-cycle pulse

## Operation
- States: IDLE, BUSY_I, BUSY_D, RECOVER.
- IDLE: requester active if read|write. None active -> stay. Only one -> grant it. Both -> dcache wins unless starve_cnt >= STARVE_LIMIT, then icache wins.
- starve_cnt (4 bits): +1 (saturating at 15) when both active and dcache granted; cleared when icache granted; unchanged otherwise.
- On grant: latch address (low 5 bits zeroed), wdata, op into output registers; read and write both set -> write only forwarded (read dropped). Go to BUSY_I/BUSY_D.
- BUSY_x: outputs held constant regardless of requester inputs (dropping the request mid-transaction does not abort). On cache_resp: that requester's resp = 1 same cycle; cache_read/cache_write cleared; go RECOVER.
- RECOVER: one cycle, no grants (lets requester FSM drop its stale request); -> IDLE.
- instr_pmem_to_cache and data_pmem_to_cache both driven from pmem_to_cache at all times; only the resp strobe is steered.
- cache_resp in IDLE/RECOVER ignored; no requester resp asserted.
- Requester resp outputs are combinational: state==BUSY_x && cache_resp.

## Timing
- Reset: state IDLE, starve_cnt 0, cache_read 0, cache_write 0, cache_address 0, cache_to_pmem 0; instr/data resp 0.
- Request sampled in IDLE at cycle N -> cache_read/write high from N+1.
- cache_resp at cycle M -> requester resp at M; cache_read/write low at M+1 (RECOVER); IDLE at M+2; next grant visible at M+3.
- Back-to-back dead time between transactions: 2 cycles minimum.
- rst during BUSY: next cycle IDLE, downstream read/write low, in-flight transaction discarded (adaptor reset by same rst).
- Request rising in RECOVER is not lost: sampled in following IDLE.

## Structure
- line_t (256-bit) and rv32i_word come from existing shared packages; add arb_state_t (IDLE, BUSY_I, BUSY_D, RECOVER) to adaptor_types.
- Optional sub-module mem_line_arbiter_pick: combinational winner select from two active flags plus starve_cnt; all registers stay in the top.

## Test plan
- Lone icache read 0x0000_0064 -> cache_address 0x0000_0060, cache_read high next cycle; adaptor resp at 10 cycles -> instr_cache_resp 1 for exactly one cycle, data_cache_resp 0, line matches.
- Simultaneous icache read and dcache write 0x8000_0020 -> dcache served first with cache_write=1, wdata forwarded; icache served after 2-cycle gap.
- STARVE_LIMIT=2, dcache requests continuously with icache pending -> grant order D, D, I, D, D, I; starve_cnt resets to 0 on each I grant.
- dcache drops data_cache_read in middle of BUSY_D -> cache_read and cache_address stay constant until cache_resp.
- Requester asserts read and write together -> only cache_write=1 downstream.
- rst asserted in BUSY_I -> next cycle cache_read 0, state IDLE; spurious cache_resp afterward produces no requester resp.
